simon_sequence_player: RTL and testbench

- Consumes the slow toggle produced by the board clock divider and plays a pseudo-random Simon LED sequence on the four Go Board LEDs.
- The slow toggle is treated as data, never as a clock: it is synchronised and edge-detected into a one-cycle tick in the i_Clk domain.
- Each tick advances the playback.
- The game FSM requests playback with a start pulse and waits for done.

---
 rtl/simon_pkg.sv | 30 +++
 rtl/slow_tick_sync.sv | 30 +++
 rtl/simon_sequence_player.sv | 163 ++++++++++++++++
 tb/tb_simon_sequence_player.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/simon_pkg.sv
// Shared constants for the Simon sequence player: FSM encoding, LFSR shape,
// default seed and LED patterns.
package simon_pkg;

    localparam int          LEVEL_W      = 5;
    localparam int          LFSR_W       = 16;
    // Taps 16,14,13,11 expressed as bit positions 15,13,12,10.
    localparam logic [15:0] LFSR_TAPS    = 16'hB400;
    localparam logic [15:0] DEFAULT_SEED = 16'hACE1;

    localparam logic [3:0]  LED_DARK     = 4'b0000;
    localparam logic [3:0]  LED_ALL      = 4'b1111;

    typedef logic [2:0] state_t;
    localparam state_t ST_IDLE   = 3'd0;
    localparam state_t ST_ARM    = 3'd1;
    localparam state_t ST_ON     = 3'd2;
    localparam state_t ST_OFF    = 3'd3;
    localparam state_t ST_FINISH = 3'd4;
    localparam state_t ST_FLASH  = 3'd5;

    function automatic logic [15:0] lfsr_next(input logic [15:0] s);
        return {s[14:0], ^(s & LFSR_TAPS)};
    endfunction

    function automatic logic [3:0] led_onehot(input logic [1:0] sel);
        return 4'b0001 << sel;
    endfunction

endpackage

// File: rtl/slow_tick_sync.sv
// Brings the divided slow square wave into the i_Clk domain as data and
// turns each synchronised rising edge into a single-cycle tick.
module slow_tick_sync (
    input  logic i_Clk,
    input  logic i_Rst,
    input  logic i_Slow_Clk,
    output logic o_Tick
);

    logic [1:0] sync_q, sync_d;
    logic       prev_q, prev_d;

    always_comb begin
        sync_d = {sync_q[0], i_Slow_Clk};
        prev_d = sync_q[1];
    end

    always_ff @(posedge i_Clk or posedge i_Rst) begin
        if (i_Rst) begin
            sync_q <= 2'b00;
            prev_q <= 1'b0;
        end else begin
            sync_q <= sync_d;
            prev_q <= prev_d;
        end
    end

    assign o_Tick = sync_q[1] & ~prev_q;

endmodule

// File: rtl/simon_sequence_player.sv
// Plays a seeded pseudo-random Simon LED sequence, one lit/dark pair per
// slow-clock tick pair. Define SIMON_END_FLASH_EN for an all-LED end flash.
module simon_sequence_player #(
    parameter int          MAX_LEVEL    = 31,
    parameter logic [15:0] DEFAULT_SEED = simon_pkg::DEFAULT_SEED,
    localparam int         LVL_W        = $clog2(MAX_LEVEL + 1)
) (
    input  logic             i_Clk,
    input  logic             i_Rst,
    input  logic             i_Slow_Clk,
    input  logic             i_Start,
    input  logic [LVL_W-1:0] i_Level,
    input  logic [15:0]      i_Seed,
    output logic [3:0]       o_LED,
    output logic             o_Busy,
    output logic             o_Done,
    output logic [LVL_W-1:0] o_Step_Idx
);

    import simon_pkg::*;

    state_t           state_q, state_d;
    logic [LVL_W-1:0] level_q, level_d;
    logic [LVL_W-1:0] step_q, step_d;
    logic [15:0]      lfsr_q, lfsr_d;
    logic [3:0]       led_q, led_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             tick;
    logic             start_ok;
    logic             last_step;

    slow_tick_sync u_tick (
        .i_Clk      (i_Clk),
        .i_Rst      (i_Rst),
        .i_Slow_Clk (i_Slow_Clk),
        .o_Tick     (tick)
    );

    // A start in the o_Done cycle is refused so a restart lands strictly after it.
    assign start_ok  = (state_q == ST_IDLE) && i_Start && !done_q;
    assign last_step = (step_q == level_q - LVL_W'(1));

    always_ff @(posedge i_Clk or posedge i_Rst) begin
        if (i_Rst) begin
            state_q <= ST_IDLE;
            step_q  <= '0;
            lfsr_q  <= DEFAULT_SEED;
            led_q   <= LED_DARK;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            step_q  <= step_d;
            lfsr_q  <= lfsr_d;
            led_q   <= led_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    always_ff @(posedge i_Clk) begin
        level_q <= level_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (start_ok) begin
                    state_d = (i_Level == '0) ? ST_FINISH : ST_ARM;
                end
            end
            ST_ARM: begin
                if (tick) state_d = ST_ON;
            end
            ST_ON: begin
                if (tick) state_d = ST_OFF;
            end
            ST_OFF: begin
                if (tick) begin
`ifdef SIMON_END_FLASH_EN
                    state_d = last_step ? ST_FLASH : ST_ON;
`else
                    state_d = last_step ? ST_FINISH : ST_ON;
`endif
                end
            end
`ifdef SIMON_END_FLASH_EN
            ST_FLASH: begin
                if (tick) state_d = ST_FINISH;
            end
`endif
            ST_FINISH: state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    // Outputs are registered; each value is set on the transition that enters its state.
    always_comb begin
        level_d = level_q;
        step_d  = step_q;
        lfsr_d  = lfsr_q;
        led_d   = led_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start_ok) begin
                    level_d = i_Level;
                    lfsr_d  = (i_Seed == 16'h0000) ? DEFAULT_SEED : i_Seed;
                    step_d  = '0;
                    led_d   = LED_DARK;
                    busy_d  = 1'b1;
                end
            end
            ST_ARM: begin
                if (tick) led_d = led_onehot(lfsr_q[1:0]);
            end
            ST_ON: begin
                if (tick) begin
                    led_d  = LED_DARK;
                    lfsr_d = lfsr_next(lfsr_q);
                end
            end
            ST_OFF: begin
                if (tick) begin
                    if (last_step) begin
`ifdef SIMON_END_FLASH_EN
                        led_d = LED_ALL;
`else
                        led_d = LED_DARK;
`endif
                    end else begin
                        step_d = step_q + LVL_W'(1);
                        led_d  = led_onehot(lfsr_q[1:0]);
                    end
                end
            end
`ifdef SIMON_END_FLASH_EN
            ST_FLASH: begin
                if (tick) led_d = LED_DARK;
            end
`endif
            ST_FINISH: begin
                done_d = 1'b1;
                busy_d = 1'b0;
                led_d  = LED_DARK;
                step_d = '0;
            end
            default: begin
                led_d  = LED_DARK;
                busy_d = 1'b0;
            end
        endcase
    end

    assign o_LED      = led_q;
    assign o_Busy     = busy_q;
    assign o_Done     = done_q;
    assign o_Step_Idx = step_q;

endmodule

// File: tb/tb_simon_sequence_player.sv
// Bench for simon_sequence_player: directed and random playbacks checked
// against a sequence model built from the LFSR rule and the lit/dark timing.
module tb_simon_sequence_player;

    logic        i_Clk      = 1'b0;
    logic        i_Rst      = 1'b1;
    logic        i_Slow_Clk = 1'b0;
    logic        i_Start    = 1'b0;
    logic [4:0]  i_Level    = 5'd0;
    logic [15:0] i_Seed     = 16'h0;
    logic [3:0]  o_LED;
    logic        o_Busy;
    logic        o_Done;
    logic [4:0]  o_Step_Idx;

    int n_pass  = 0;
    int n_total = 0;

`ifdef SIMON_END_FLASH_EN
    localparam int FLASH = 1;
`else
    localparam int FLASH = 0;
`endif
    localparam int HALF_SLOW = 20;

    simon_sequence_player dut (
        .i_Clk      (i_Clk),
        .i_Rst      (i_Rst),
        .i_Slow_Clk (i_Slow_Clk),
        .i_Start    (i_Start),
        .i_Level    (i_Level),
        .i_Seed     (i_Seed),
        .o_LED      (o_LED),
        .o_Busy     (o_Busy),
        .o_Done     (o_Done),
        .o_Step_Idx (o_Step_Idx)
    );

    always #5 i_Clk = ~i_Clk;

    always begin
        repeat (HALF_SLOW) @(negedge i_Clk);
        i_Slow_Clk = ~i_Slow_Clk;
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // Step k of a seed shows one-hot(state[1:0]) after k LFSR shifts.
    function automatic logic [3:0] model_led(input logic [15:0] seed, input int k);
        logic [15:0] s;
        s = (seed == 16'h0000) ? 16'hACE1 : seed;
        for (int i = 0; i < k; i++) s = {s[14:0], s[15] ^ s[13] ^ s[12] ^ s[10]};
        return 4'b0001 << s[1:0];
    endfunction

    // Entered and left just after a falling clock edge.
    task automatic play(input logic [15:0] seed, input logic [4:0] level, input int inj_step,
                        input bit start_on_done, input string tag,
                        output logic [63:0] sig, output logic [3:0] first_led);
        logic [3:0] lit_val [64];
        int         lit_step[64];
        int         lit_len [64];
        int         dark_len[64];
        int         n_lit = 0, c = 0, rise_c = 0, fall_c = 0, done_c = -1;
        int         busy_drop = 0, bad_led = 0, budget, exp_n, lim;
        bit         injected = 1'b0;
        logic [3:0] prev = 4'h0, led, exp_v;

        exp_n  = (level == 5'd0) ? 0 : int'(level) + FLASH;
        budget = 100 * int'(level) + 300;
        sig = 64'h0;
        first_led = 4'h0;

        i_Seed = seed; i_Level = level; i_Start = 1'b1;
        @(negedge i_Clk);
        i_Start = 1'b0; i_Seed = 16'($urandom); i_Level = 5'($urandom);
        chk({tag, ".accept_busy"}, 64'(o_Busy), 64'd1);

        while (c < budget) begin
            c++;
            led = o_LED;
            if (o_Done) begin
                done_c = c;
                break;
            end
            if (!o_Busy) busy_drop++;
            if (!(led inside {4'h0, 4'h1, 4'h2, 4'h4, 4'h8, 4'hF})) bad_led++;
            if (prev == 4'h0 && led != 4'h0) begin
                if (n_lit < 64) begin
                    lit_val[n_lit]  = led;
                    lit_step[n_lit] = int'(o_Step_Idx);
                    if (n_lit > 0) dark_len[n_lit-1] = c - fall_c;
                end
                n_lit++;
                rise_c = c;
            end else if (prev != 4'h0 && led == 4'h0) begin
                if (n_lit > 0 && n_lit <= 64) lit_len[n_lit-1] = c - rise_c;
                fall_c = c;
            end
            prev = led;
            if (i_Start) begin
                i_Start = 1'b0;
            end else if (inj_step >= 0 && !injected && led != 4'h0 && int'(o_Step_Idx) == inj_step) begin
                injected = 1'b1;
                i_Start  = 1'b1;
                i_Seed   = 16'($urandom);
                i_Level  = 5'd7;
            end
            @(negedge i_Clk);
        end
        i_Start = 1'b0;

        chk({tag, ".done_seen"}, 64'(done_c > 0), 64'd1);
        chk({tag, ".lit_count"}, 64'(n_lit), 64'(exp_n));
        chk({tag, ".busy_held"}, 64'(busy_drop), 64'd0);
        chk({tag, ".led_legal"}, 64'(bad_led), 64'd0);
        if (inj_step >= 0) chk({tag, ".injected"}, 64'(injected), 64'd1);

        lim = (n_lit < exp_n) ? n_lit : exp_n;
        if (lim > 64) lim = 64;
        for (int k = 0; k < lim; k++) begin
            exp_v = (k < int'(level)) ? model_led(seed, k) : 4'hF;
            chk($sformatf("%s.led[%0d]", tag, k), 64'(lit_val[k]), 64'(exp_v));
            if (k < int'(level)) chk($sformatf("%s.idx[%0d]", tag, k), 64'(lit_step[k]), 64'(k));
            chk($sformatf("%s.lit_len[%0d]", tag, k), 64'(lit_len[k]), 64'(2 * HALF_SLOW));
            if (k < lim - 1) chk($sformatf("%s.dark_len[%0d]", tag, k), 64'(dark_len[k]), 64'(2 * HALF_SLOW));
        end
        for (int k = 0; k < lim; k++) sig = sig * 64'd17 + 64'(lit_val[k]) + 64'd1;
        if (n_lit > 0) first_led = lit_val[0];

        if (done_c > 0) begin
            chk({tag, ".done_busy"}, 64'(o_Busy), 64'd0);
            chk({tag, ".done_idx"}, 64'(o_Step_Idx), 64'd0);
            chk({tag, ".done_led"}, 64'(o_LED), 64'd0);
            if (level == 5'd0)
                chk({tag, ".done_latency"}, 64'(done_c), 64'd2);
            else
                chk({tag, ".tail_to_done"}, 64'(done_c - fall_c), 64'((FLASH != 0) ? 1 : 2 * HALF_SLOW + 1));
            if (start_on_done) begin
                i_Start = 1'b1; i_Seed = 16'($urandom); i_Level = 5'd3;
                @(negedge i_Clk);
                i_Start = 1'b0;
                chk({tag, ".start_on_done_ignored"}, 64'(o_Busy), 64'd0);
            end else begin
                @(negedge i_Clk);
            end
            chk({tag, ".done_single"}, 64'(o_Done), 64'd0);
        end
    endtask

    initial begin
        logic [63:0] sig_a, sig_b, sig_z, sig_x;
        logic [3:0]  fl;
        logic [15:0] seed_r;
        int          w;

        repeat (2) @(negedge i_Clk);
        chk("rst.led", 64'(o_LED), 64'd0);
        chk("rst.busy", 64'(o_Busy), 64'd0);
        chk("rst.done", 64'(o_Done), 64'd0);
        chk("rst.idx", 64'(o_Step_Idx), 64'd0);
        i_Rst = 1'b0;
        repeat (3) @(negedge i_Clk);

        play(16'h0001, 5'd1, -1, 1'b0, "lvl1_seed1", sig_x, fl);
        chk("lvl1_seed1.first_led", 64'(fl), 64'h2);

        play(16'hACE1, 5'd4, -1, 1'b0, "lvl4_a", sig_a, fl);
        play(16'hACE1, 5'd4, -1, 1'b0, "lvl4_b", sig_b, fl);
        chk("lvl4.replay_identical", sig_b, sig_a);
        play(16'h0000, 5'd4, -1, 1'b0, "seed0", sig_z, fl);
        chk("seed0.same_as_ace1", sig_z, sig_a);

        play(16'($urandom), 5'd0, -1, 1'b0, "lvl0", sig_x, fl);
        play(16'($urandom), 5'd3, 2, 1'b0, "busy_start", sig_x, fl);
        play(16'hACE1, 5'd1, -1, 1'b1, "done_start", sig_x, fl);
        play(16'h1234, 5'd2, -1, 1'b0, "restart_after_done", sig_x, fl);

        seed_r = 16'($urandom);
        i_Seed = seed_r; i_Level = 5'd5; i_Start = 1'b1;
        @(negedge i_Clk);
        i_Start = 1'b0;
        w = 0;
        while (!(o_Step_Idx == 5'd2 && o_LED != 4'h0) && w < 1000) begin
            @(negedge i_Clk);
            w++;
        end
        chk("midrst.reached_step2", 64'(w < 1000), 64'd1);
        #2 i_Rst = 1'b1;
        #1;
        chk("midrst.led", 64'(o_LED), 64'd0);
        chk("midrst.busy", 64'(o_Busy), 64'd0);
        chk("midrst.done", 64'(o_Done), 64'd0);
        chk("midrst.idx", 64'(o_Step_Idx), 64'd0);
        w = 0;
        repeat (3) begin
            @(negedge i_Clk);
            if (o_Done) w++;
        end
        i_Rst = 1'b0;
        repeat (2) begin
            @(negedge i_Clk);
            if (o_Done) w++;
        end
        chk("midrst.no_done", 64'(w), 64'd0);
        play(seed_r, 5'd2, -1, 1'b0, "midrst.replay", sig_x, fl);

        for (int r = 0; r < 4; r++) begin
            play(16'($urandom), 5'($urandom_range(1, 5)), -1, 1'b0,
                 $sformatf("rand%0d", r), sig_x, fl);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
